data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LINE_W, default 256, width of one cache line in bits.
REQ-002 Parameter DEPTH, default 512, number of lines stored.
REQ-003 Parameter LATENCY, default 10, cycles from request acceptance to ack; legal range 2..255.
REQ-004 clk_i  input  1  single clock, rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-low.
REQ-006 enable_i  input  1  request valid, held by the requester until ack_o.
REQ-007 write_i  input  1  1 = line write, 0 = line read; meaningful only with enable_i.
REQ-008 addr_i  input  32  byte address; line index = addr_i[13:5], other bits ignored.
REQ-009 data_i  input  LINE_W  write line data.
REQ-010 ack_o  output  1  one-cycle completion pulse.
REQ-011 data_o  output  LINE_W  read line data, valid while ack_o=1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, WAIT, ACK.
REQ-013 IDLE SHALL go to WAIT when enable_i=1 on a clock edge; this latches write_i, addr_i[13:5] and data_i and clears the latency counter.
REQ-014 WAIT SHALL increment an 8-bit counter each cycle and go to ACK on the edge where the counter equals LATENCY-2.
REQ-015 The first ack_o=1 cycle SHALL therefore occur exactly LATENCY cycles after the accepting edge.
REQ-016 ACK SHALL drive ack_o=1 for exactly one cycle and return unconditionally to IDLE.
REQ-017 In ACK with latched write=0, data_o SHALL equal the stored line at the latched index.
REQ-018 In ACK with latched write=1, data_o SHALL be 0, and the latched data SHALL be stored at the latched index on the edge leaving ACK.
REQ-019 Outside ACK, ack_o SHALL be 0 and data_o SHALL be 0.
REQ-020 Changes to enable_i, write_i, addr_i or data_i during WAIT or ACK SHALL be ignored; only latched values are used.
REQ-021 A new request SHALL be accepted no earlier than the IDLE cycle after ACK, so back-to-back requests are separated by at least one idle cycle.
REQ-022 A read of a line written by the immediately preceding request SHALL return the new data.
REQ-023 Address aliasing is defined behaviour: addresses equal in bits [13:5] SHALL map to the same line.

Reset
REQ-024 While rst_i=0 at a clock edge, the FSM SHALL enter IDLE, the counter SHALL clear to 0, and ack_o and data_o SHALL be 0.
REQ-025 A reset during WAIT or ACK SHALL abort the request with no ack and no array write.
REQ-026 Array contents SHALL NOT be reset; tests preload them from a hex file at time zero.

Structure
REQ-027 LINE_W, the index field bounds [13:5], and the state encoding SHALL live in a shared package used by both data_memory and the cache controller.
REQ-028 The latency counter SHALL be one natural sub-module, mem_latency_counter: clear, enable, terminal-count compare.
REQ-029 Storage SHALL be a single behavioural array of DEPTH x LINE_W with a single read/write port.

Verification
REQ-030 Read latency: preload line 3 = 256'hA5..A5, then enable_i=1, write_i=0, addr_i=32'h60 -> ack_o=1 exactly 10 cycles after acceptance, data_o=A5..A5, and ack_o=0 on the next cycle.
REQ-031 Write then read: write addr 32'h80 with data {8{32'hDEADBEEF}}, then read addr 32'h80 -> the read ack returns {8{32'hDEADBEEF}}, and the write ack cycle shows data_o=0.
REQ-032 Input changes mid-request: start a read at 32'h20, change addr_i to 32'h40 and write_i to 1 during WAIT -> the ack returns line 1, and line 2 is unmodified.
REQ-033 Reset mid-operation: issue a write to 32'hA0, pull rst_i=0 for one cycle at count 5, then read 32'hA0 -> no ack for the aborted write, and the read returns the preloaded value.
REQ-034 Aliasing and hold: write 32'h0000_4020 (index 1), then read 32'h20 -> the read returns the written data; enable_i held high through ack -> second acceptance occurs on the IDLE cycle after ack.
REQ-035 LATENCY=2 build: a read acks exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared definitions for the line-granular data memory and the cache controller.
// Holds the default line width, the address index field bounds, the latency
// counter width, the three-state FSM encoding and the latched request payload.
package data_memory_pkg;

  localparam int unsigned LINE_W_DEF = 256;
  localparam int unsigned IDX_LSB    = 5;
  localparam int unsigned IDX_MSB    = 13;
  localparam int unsigned IDX_W      = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } mem_state_e;

  // Request fields captured at acceptance (line data is kept separately
  // because its width is a module parameter).
  typedef struct packed {
    logic             write;
    logic [IDX_W-1:0] idx;
  } mem_req_t;

  // Line index of a byte address; bits outside the field are ignored.
  function automatic logic [IDX_W-1:0] line_index(input logic [ADDR_W-1:0] addr);
    return addr[IDX_MSB:IDX_LSB];
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/ack bus between a requester (master) and data_memory (slave).
//   enable_i : request valid, held by the requester until ack_o
//   write_i  : 1 = line write, 0 = line read
//   addr_i   : byte address, line index in [13:5]
//   data_i   : write line data
//   ack_o    : one-cycle completion pulse
//   data_o   : read line data, valid while ack_o=1
interface data_memory_if import data_memory_pkg::*; #(
  parameter int unsigned LINE_W = LINE_W_DEF
) ();

  logic              enable_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );

endinterface

// File: rtl/mem_latency_counter.sv
// Latency counter for data_memory: synchronous clear, count enable and a
// combinational terminal-count compare against a supplied value.
//   clk_i, rst_i : clock, synchronous active-low reset
//   clr_i        : clear count to 0 (wins over en_i)
//   en_i         : increment count by one
//   tc_val_i     : terminal count value
//   tc_c         : count equals tc_val_i
module mem_latency_counter import data_memory_pkg::*; (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == tc_val_i);

endmodule

// File: rtl/data_memory.sv
// Fixed-latency line memory. A request accepted in IDLE spends LATENCY-1
// cycles in WAIT and one cycle in ACK, so ack_o is high in the LATENCY-th
// cycle after the accepting edge. Reads are captured on the edge entering
// ACK; writes commit on the edge leaving ACK. Array contents are not reset.
//   clk_i, rst_i : clock, synchronous active-low reset
//   bus          : slave side of data_memory_if (request in, ack/data out)
module data_memory import data_memory_pkg::*; #(
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10
) (
  input logic           clk_i,
  input logic           rst_i,
  data_memory_if.slave  bus
);

  // WAIT ends on the edge where the count equals LATENCY-2.
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LATENCY - 2);

  mem_state_e        state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;

  logic [LINE_W-1:0] mem_q [DEPTH];

  logic accept_c;
  logic cnt_en_c;
  logic cnt_tc_c;
  logic mem_we_c;
  logic unused_addr_c;

  assign unused_addr_c = ^{bus.addr_i[ADDR_W-1:IDX_MSB+1], bus.addr_i[IDX_LSB-1:0]};

  mem_latency_counter u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (accept_c),
    .en_i     (cnt_en_c),
    .tc_val_i (TC_VAL),
    .tc_c     (cnt_tc_c)
  );

  // Next state, request capture and registered-output values
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    rdata_d  = '0;
    accept_c = 1'b0;
    cnt_en_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable_i) begin
          accept_c = 1'b1;
          req_d    = '{write: bus.write_i, idx: line_index(bus.addr_i)};
          wdata_d  = bus.data_i;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_en_c = 1'b1;
        if (cnt_tc_c) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (!req_q.write) begin
            rdata_d = mem_q[req_q.idx];
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // A reset on the edge leaving ACK aborts the write.
  assign mem_we_c = (state_q == ST_ACK) && req_q.write && rst_i;

  // Line storage, single port: write leaves ACK, read enters ACK
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      mem_q[req_q.idx] <= wdata_q;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory. Latency is counted in cycles after the
// accepting edge: the cycle right after that edge is cycle 1.
module tb_data_memory;
  import data_memory_pkg::*;

  typedef logic [255:0] line_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  data_memory_if #(.LINE_W(256)) bus  ();
  data_memory_if #(.LINE_W(256)) bus2 ();

  data_memory #(.LINE_W(256), .DEPTH(512), .LATENCY(10)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  data_memory #(.LINE_W(256), .DEPTH(512), .LATENCY(2)) dut2 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input line_t got, input line_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on the LATENCY=10 port; returns ack cycle (-1 on timeout),
  // ack data and whether data_o was nonzero outside the ack cycle.
  task automatic do_req(input logic wr, input logic [31:0] addr, input line_t data,
                        input bit perturb, output int lat, output line_t rdata,
                        output bit leak);
    lat   = -1;
    rdata = '0;
    leak  = 1'b0;
    bus.enable_i = 1'b0;
    tick();
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = addr;
    bus.data_i   = data;
    tick();
    bus.enable_i = 1'b0;
    if (perturb) begin
      bus.write_i = 1'b1;
      bus.addr_i  = 32'h40;
      bus.data_i  = {64{4'hF}};
    end
    for (int c = 1; c <= 300; c++) begin
      if (bus.ack_o) begin
        lat   = c;
        rdata = bus.data_o;
        break;
      end
      if (bus.data_o != '0) leak = 1'b1;
      tick();
    end
    tick();
  endtask

  line_t p1, p2, p3, p5, dead, q, z, rd;
  int    lat, acks, ack1, ack2;
  bit    leak;
  line_t d1, d2;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    p1   = {16{16'h1111}};
    p2   = {16{16'h2222}};
    p3   = {32{8'hA5}};
    p5   = {16{16'h5555}};
    dead = {8{32'hDEADBEEF}};
    q    = {8{32'h0BADCAFE}};
    z    = {8{32'h12345678}};

    rst_n = 1'b0;
    bus.enable_i = 1'b0; bus.write_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
    bus2.enable_i = 1'b0; bus2.write_i = 1'b0; bus2.addr_i = '0; bus2.data_i = '0;
    tick();
    tick();
    check_eq("reset_ack", line_t'(bus.ack_o), line_t'(0));
    check_eq("reset_data", bus.data_o, '0);
    rst_n = 1'b1;

    // Preload lines 1, 2, 3, 5 through the bus
    do_req(1'b1, 32'h20, p1, 1'b0, lat, rd, leak);
    do_req(1'b1, 32'h40, p2, 1'b0, lat, rd, leak);
    do_req(1'b1, 32'h60, p3, 1'b0, lat, rd, leak);
    do_req(1'b1, 32'hA0, p5, 1'b0, lat, rd, leak);
    check_eq("preload_write_lat", line_t'(lat), line_t'(10));

    // Read latency
    do_req(1'b0, 32'h60, '0, 1'b0, lat, rd, leak);
    check_eq("read_lat", line_t'(lat), line_t'(10));
    check_eq("read_data", rd, p3);
    check_eq("read_no_leak", line_t'(leak), line_t'(0));
    check_eq("post_ack_low", line_t'(bus.ack_o), line_t'(0));
    check_eq("post_ack_data", bus.data_o, '0);

    // Write then read
    do_req(1'b1, 32'h80, dead, 1'b0, lat, rd, leak);
    check_eq("write_lat", line_t'(lat), line_t'(10));
    check_eq("write_ack_data", rd, '0);
    do_req(1'b0, 32'h80, '0, 1'b0, lat, rd, leak);
    check_eq("raw_data", rd, dead);

    // Input changes during WAIT are ignored
    do_req(1'b0, 32'h20, '0, 1'b1, lat, rd, leak);
    check_eq("perturb_lat", line_t'(lat), line_t'(10));
    check_eq("perturb_data", rd, p1);
    do_req(1'b0, 32'h40, '0, 1'b0, lat, rd, leak);
    check_eq("line2_intact", rd, p2);

    // Reset at count 5 aborts a write to line 5
    bus.enable_i = 1'b0;
    tick();
    bus.enable_i = 1'b1; bus.write_i = 1'b1; bus.addr_i = 32'hA0; bus.data_i = dead;
    tick();
    bus.enable_i = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("abort_ack", line_t'(bus.ack_o), line_t'(0));
    acks = 0;
    repeat (15) begin
      if (bus.ack_o) acks++;
      tick();
    end
    check_eq("abort_no_ack", line_t'(acks), line_t'(0));
    do_req(1'b0, 32'hA0, '0, 1'b0, lat, rd, leak);
    check_eq("abort_lat", line_t'(lat), line_t'(10));
    check_eq("abort_data", rd, p5);

    // Aliasing: 0x4020 and 0x20 share line 1
    do_req(1'b1, 32'h0000_4020, q, 1'b0, lat, rd, leak);
    do_req(1'b0, 32'h20, '0, 1'b0, lat, rd, leak);
    check_eq("alias_data", rd, q);

    // Enable held through ack: second acceptance on the IDLE cycle after ack
    bus.enable_i = 1'b0;
    tick();
    bus.enable_i = 1'b1; bus.write_i = 1'b0; bus.addr_i = 32'h60;
    tick();
    ack1 = -1; ack2 = -1; d1 = '0; d2 = '0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.ack_o) begin
        if (ack1 < 0) begin
          ack1 = c; d1 = bus.data_o;
        end else begin
          ack2 = c; d2 = bus.data_o;
          bus.enable_i = 1'b0;
          break;
        end
      end
      tick();
    end
    bus.enable_i = 1'b0;
    tick();
    tick();
    check_eq("hold_ack1", line_t'(ack1), line_t'(10));
    check_eq("hold_ack2", line_t'(ack2), line_t'(21));
    check_eq("hold_data1", d1, p3);
    check_eq("hold_data2", d2, p3);

    // LATENCY=2 instance: write then read line 3
    for (int op = 0; op < 2; op++) begin
      bus2.enable_i = 1'b0;
      tick();
      bus2.enable_i = 1'b1;
      bus2.write_i  = (op == 0);
      bus2.addr_i   = 32'h60;
      bus2.data_i   = z;
      tick();
      bus2.enable_i = 1'b0;
      lat = -1;
      rd  = '0;
      for (int c = 1; c <= 20; c++) begin
        if (bus2.ack_o) begin
          lat = c; rd = bus2.data_o;
          break;
        end
        tick();
      end
      tick();
      check_eq(op == 0 ? "l2_write_lat" : "l2_read_lat", line_t'(lat), line_t'(2));
      check_eq(op == 0 ? "l2_write_data" : "l2_read_data", rd, op == 0 ? line_t'(0) : z);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
